// File: rtl/emg_servo_array.sv
// emg_servo_array: per-channel EMG grip detector with hysteresis/debounce driving slew-limited servo PWM.
module emg_servo_array #(
  parameter int NCH        = 2,
  parameter int DW         = 8,
  parameter int SAMPLE_DIV = 50,
  parameter int FRAME_CYC  = 1000000,
  parameter int PW_MIN     = 50000,
  parameter int PW_MAX     = 100000,
  parameter int STEP       = 5000,
  parameter int TH_HI      = 200,
  parameter int TH_LO      = 50,
  parameter int DEBOUNCE   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NCH*DW-1:0] d,
  output logic [NCH-1:0]    servo_pwm,
  output logic [NCH-1:0]    grip,
  output logic              frame_tick
);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int FW = $clog2(FRAME_CYC);
  localparam int BW = $clog2(DEBOUNCE + 1);
  logic [SW-1:0] sc;
  logic [FW-1:0] fc;
  logic          st;
  assign st         = sc == SW'(SAMPLE_DIV - 1);
  assign frame_tick = fc == FW'(FRAME_CYC - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc <= '0;
      fc <= '0;
    end else begin
      sc <= st ? '0 : sc + SW'(1);
      fc <= frame_tick ? '0 : fc + FW'(1);
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] s;
    logic [BW-1:0] dbc;
    logic [FW-1:0] pw, tgt, diff;
    logic          qual, g, p, done;
    assign s    = d[i*DW +: DW];
    // a qualifying sample is one that argues for leaving the current grip state
    assign qual = g ? s <= DW'(TH_LO) : s >= DW'(TH_HI);
    assign done = qual && dbc == BW'(DEBOUNCE - 1);
    assign tgt  = g ? FW'(PW_MAX) : FW'(PW_MIN);
    assign diff = pw < tgt ? tgt - pw : pw - tgt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dbc <= '0;
        g   <= 1'b0;
        pw  <= FW'(PW_MIN);
        p   <= 1'b0;
      end else begin
        p <= en & (fc < pw);
        if (st) begin
          dbc <= (qual && !done) ? dbc + BW'(1) : '0;
          if (done) g <= ~g;
        end
        if (frame_tick) pw <= diff <= FW'(STEP) ? tgt : pw < tgt ? pw + FW'(STEP) : pw - FW'(STEP);
      end
    end
    assign grip[i]      = g;
    assign servo_pwm[i] = p;
  end
endmodule

// File: tb/tb_emg_servo_array.sv
// tb_emg_servo_array: random and directed stimulus against a cycle-count based reference model.
module tb_emg_servo_array;
  localparam int NCH = 2, DW = 8, SDIV = 4, FRM = 100, PWMIN = 10, PWMAX = 20, STP = 4;
  localparam int THH = 200, THL = 50, DEB = 3;
  logic clk = 0, reset_n = 0, en = 1;
  logic [NCH*DW-1:0] d = '0;
  logic [NCH-1:0] servo_pwm, grip;
  logic frame_tick;
  int checks = 0, errors = 0;
  int k;
  int pw [NCH];
  int run [NCH];
  bit g [NCH];
  bit ep [NCH];

  emg_servo_array #(.NCH(NCH), .DW(DW), .SAMPLE_DIV(SDIV), .FRAME_CYC(FRM), .PW_MIN(PWMIN),
    .PW_MAX(PWMAX), .STEP(STP), .TH_HI(THH), .TH_LO(THL), .DEBOUNCE(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .d(d),
    .servo_pwm(servo_pwm), .grip(grip), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: k counts clocks since reset release, so frame position is k%FRM and sample ticks fall on k%SDIV==SDIV-1
  always @(posedge clk) begin
    if (!reset_n) begin
      k = 0;
      for (int c = 0; c < NCH; c++) begin pw[c] = PWMIN; run[c] = 0; g[c] = 0; ep[c] = 0; end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int sv, tg;
        ep[c] = en && (k % FRM) < pw[c];
        if (k % FRM == FRM - 1) begin
          tg = g[c] ? PWMAX : PWMIN;
          if (tg > pw[c]) pw[c] = (tg - pw[c] < STP) ? tg : pw[c] + STP;
          else pw[c] = (pw[c] - tg < STP) ? tg : pw[c] - STP;
        end
        if (k % SDIV == SDIV - 1) begin
          sv = int'(d[c*DW +: DW]);
          if (g[c] ? sv <= THL : sv >= THH) run[c]++;
          else run[c] = 0;
          if (run[c] == DEB) begin g[c] = !g[c]; run[c] = 0; end
        end
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("servo_rst", int'(servo_pwm), 0);
      chk("grip_rst", int'(grip), 0);
      chk("tick_rst", int'(frame_tick), 0);
    end else begin
      chk("servo", int'(servo_pwm), int'({ep[1], ep[0]}));
      chk("grip", int'(grip), int'({g[1], g[0]}));
      chk("frame_tick", int'(frame_tick), int'(k % FRM == FRM - 1));
    end
  end

  task automatic measure(output int c0, output int c1, output int ft);
    c0 = 0; c1 = 0; ft = 0;
    repeat (FRM) begin
      @(negedge clk);
      c0 += int'(servo_pwm[0]);
      c1 += int'(servo_pwm[1]);
      ft += int'(frame_tick);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 reset_n = 1;
  endtask

  int c0, c1, ft, bound;
  int w0 [5] = '{10, 14, 18, 20, 20};
  initial begin
    repeat (5) @(negedge clk);
    chk("lit_reset_out", int'({servo_pwm, grip, frame_tick}), 0);
    d[7:0] = 8'd220;
    release_reset();
    for (int f = 0; f < 5; f++) begin
      measure(c0, c1, ft);
      chk("lit_close_w0", c0, w0[f]);
      chk("lit_close_w1", c1, 10);
      chk("lit_frame_ticks", ft, 1);
    end
    d[7:0] = 8'd120;
    repeat (40) @(negedge clk);
    chk("lit_hyst_grip", int'(grip), 1);
    d[7:0] = 8'd40;
    repeat (8) @(negedge clk);
    d[7:0] = 8'd120;
    repeat (8) @(negedge clk);
    chk("lit_debounce_grip", int'(grip), 1);
    d[7:0] = 8'd40;
    repeat (12) @(negedge clk);
    chk("lit_open_grip", int'(grip), 0);
    repeat (150) @(negedge clk);
    en = 0;
    repeat (2) @(negedge clk);
    chk("lit_en_off", int'(servo_pwm), 0);
    repeat (145) @(negedge clk);
    en = 1;
    for (int seg = 0; seg < 800; seg++) begin
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(2))
          0: d[c*DW +: DW] = 8'($urandom_range(THL));
          1: d[c*DW +: DW] = 8'($urandom_range(THH - 1, THL + 1));
          default: d[c*DW +: DW] = 8'($urandom_range(255, THH));
        endcase
      end
      if ($urandom_range(15) == 0) en = ~en;
      repeat ($urandom_range(4, 24)) @(negedge clk);
    end
    en = 1;
    bound = 0;
    while (servo_pwm == 0 && bound < 300) begin @(negedge clk); bound++; end
    chk("pulse_seen", int'(bound < 300), 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("lit_async_servo", int'(servo_pwm), 0);
    chk("lit_async_grip", int'(grip), 0);
    d = '0;
    repeat (3) @(negedge clk);
    release_reset();
    repeat (90) @(negedge clk);
    d[7:0] = 8'd220;
    repeat (9) @(negedge clk);
    chk("lit_coinc_pre", int'(grip), 0);
    @(negedge clk);
    chk("lit_coinc_grip", int'(grip), 1);
    measure(c0, c1, ft);
    chk("lit_coinc_w_hold", c0, 10);
    measure(c0, c1, ft);
    chk("lit_coinc_w_next", c0, 14);
    chk("lit_coinc_w1", c1, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
